// File: rtl/zjh_vote_sampler.sv
// Voting-session front end for the three-input majority voter.
// Each raw key is synchronised and debounced. A timed session then latches
// one sticky vote per voter and strobes votes_valid when the votes are final.
module zjh_vote_sampler #(
  parameter int unsigned DEB_CYCLES = 4,
  parameter int unsigned WIN_CYCLES = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       key_a,
  input  logic       key_b,
  input  logic       key_c,
  output logic       vote_a,
  output logic       vote_b,
  output logic       vote_c,
  output logic       votes_valid,
  output logic       busy,
  output logic [1:0] voted_cnt
);

  localparam int unsigned DebW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned WinW = $clog2(WIN_CYCLES);
  localparam logic [DebW-1:0] DebLast = DebW'(DEB_CYCLES - 1);
  localparam logic [WinW-1:0] WinLast = WinW'(WIN_CYCLES - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCollect = 2'd1,
    StDone    = 2'd2
  } state_e;

  // Bit 0 = voter A, bit 1 = voter B, bit 2 = voter C throughout.
  logic [2:0]            key_raw;
  logic [2:0]            k_s1_q, k_s2_q;
  logic [2:0]            deb_lvl_q, deb_lvl_d;
  logic [2:0]            deb_lvl_prev_q;
  logic [2:0][DebW-1:0]  deb_cnt_q, deb_cnt_d;
  logic [2:0]            press;

  state_e                state_q, state_d;
  logic [2:0]            votes_q, votes_d;
  logic [1:0]            voted_cnt_q, voted_cnt_d;
  logic [WinW-1:0]       win_cnt_q, win_cnt_d;
  logic                  busy_q, busy_d;
  logic                  votes_valid_q, votes_valid_d;

  assign key_raw = {key_c, key_b, key_a};

  // One-cycle rising edge of each debounced level.
  assign press = deb_lvl_q & ~deb_lvl_prev_q;

  // Debounce next state: a level change is accepted only after DEB_CYCLES
  // consecutive synced samples disagree with the current level.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      deb_lvl_d[i] = deb_lvl_q[i];
      deb_cnt_d[i] = '0;
      if (k_s2_q[i] != deb_lvl_q[i]) begin
        if (deb_cnt_q[i] == DebLast) begin
          deb_lvl_d[i] = k_s2_q[i];
        end else begin
          deb_cnt_d[i] = deb_cnt_q[i] + DebW'(1);
        end
      end
    end
  end

  // Synchroniser, debounce and edge-detect registers; run in every FSM state.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_s1_q         <= '0;
      k_s2_q         <= '0;
      deb_lvl_q      <= '0;
      deb_lvl_prev_q <= '0;
      deb_cnt_q      <= '0;
    end else begin
      k_s1_q         <= key_raw;
      k_s2_q         <= k_s1_q;
      deb_lvl_q      <= deb_lvl_d;
      deb_lvl_prev_q <= deb_lvl_q;
      deb_cnt_q      <= deb_cnt_d;
    end
  end

  // Session FSM next state; presses only count while collecting.
  always_comb begin
    state_d       = state_q;
    votes_d       = votes_q;
    voted_cnt_d   = voted_cnt_q;
    win_cnt_d     = win_cnt_q;
    busy_d        = 1'b0;
    votes_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d     = StCollect;
          votes_d     = '0;
          voted_cnt_d = '0;
          win_cnt_d   = '0;
        end
      end
      StCollect: begin
        votes_d     = votes_q | press;
        voted_cnt_d = 2'(votes_d[0]) + 2'(votes_d[1]) + 2'(votes_d[2]);
        // Window end or unanimous early exit; the counter stops before it could wrap.
        if ((win_cnt_q == WinLast) || (&votes_d)) begin
          state_d = StDone;
        end else begin
          win_cnt_d = win_cnt_q + WinW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    busy_d        = (state_d == StCollect);
    votes_valid_d = (state_d == StDone);
  end

  // Session FSM state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      votes_q       <= '0;
      voted_cnt_q   <= '0;
      win_cnt_q     <= '0;
      busy_q        <= 1'b0;
      votes_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      votes_q       <= votes_d;
      voted_cnt_q   <= voted_cnt_d;
      win_cnt_q     <= win_cnt_d;
      busy_q        <= busy_d;
      votes_valid_q <= votes_valid_d;
    end
  end

  assign vote_a      = votes_q[0];
  assign vote_b      = votes_q[1];
  assign vote_c      = votes_q[2];
  assign voted_cnt   = voted_cnt_q;
  assign busy        = busy_q;
  assign votes_valid = votes_valid_q;

endmodule

// File: tb/tb_zjh_vote_sampler.sv
// Scoreboard bench for zjh_vote_sampler: each session's key waveforms are
// generated up front, the expected session outcome is derived from key timing
// arithmetic and queued, and a monitor checks every votes_valid strobe.
module tb_zjh_vote_sampler;

  localparam int unsigned Deb = 4;
  localparam int unsigned Win = 16;
  localparam int          T0  = 16;                  // waveform index where start is driven
  localparam int          Len = T0 + Win + Deb + 9;

  logic       clk = 1'b0;
  logic       rst, start, key_a, key_b, key_c;
  logic       vote_a, vote_b, vote_c, votes_valid, busy;
  logic [1:0] voted_cnt;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [2:0] v;        // bit0 = A, bit1 = B, bit2 = C
    logic [1:0] c;
    int         end_cyc;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  zjh_vote_sampler #(
    .DEB_CYCLES(Deb),
    .WIN_CYCLES(Win)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .key_a      (key_a),
    .key_b      (key_b),
    .key_c      (key_c),
    .vote_a     (vote_a),
    .vote_b     (vote_b),
    .vote_c     (vote_c),
    .votes_valid(votes_valid),
    .busy       (busy),
    .voted_cnt  (voted_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every valid strobe must match the oldest queued session.
  always @(negedge clk) begin
    if (votes_valid) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("votes_cba", int'({vote_c, vote_b, vote_a}), int'(mon_e.v));
        chk("voted_cnt", int'(voted_cnt), int'(mon_e.c));
        chk("valid_cycle", cyc, mon_e.end_cyc);
        chk("busy_at_valid", int'(busy), 0);
      end
    end
  end

  // Voter modes: 0 idle, 1 clean rise at d, 2 bounce then clean rise at d,
  // 3 bounce only. d is relative to the cycle start is driven.
  task automatic run_session(input int m0, input int m1, input int m2,
                             input int d0, input int d1, input int d2, input bit xs);
    int   md[3];
    int   dd[3];
    bit   wv[3][64];
    bit   hit[3];
    int   kk, kmax, nv, p, lim, w, s_cyc;
    exp_t e;
    md = '{m0, m1, m2};
    dd = '{d0, d1, d2};
    for (int i = 0; i < 3; i++) begin
      for (int t = 0; t < 64; t++) wv[i][t] = 1'b0;
      if (md[i] == 1 || md[i] == 2) begin
        for (int t = T0 + dd[i]; t < 64; t++) wv[i][t] = 1'b1;
      end
      if (md[i] == 2 || md[i] == 3) begin
        p   = (md[i] == 2) ? T0 + dd[i] - 12 : T0 + 2 + int'($urandom_range(0, 8));
        if (p < 1) p = 1;
        lim = (md[i] == 2) ? T0 + dd[i] - 1 : p + 12;
        while (p < lim) begin
          w = int'($urandom_range(1, Deb - 1));
          for (int j = 0; j < w; j++) if (p + j < lim) wv[i][p + j] = 1'b1;
          p = p + w + int'($urandom_range(1, 2));
        end
      end
    end
    // A clean rise at d is a debounced press during window cycle d+1+Deb.
    kmax = 0;
    nv   = 0;
    for (int i = 0; i < 3; i++) begin
      kk     = dd[i] + 1 + int'(Deb);
      hit[i] = (md[i] == 1 || md[i] == 2) && kk >= 0 && kk <= int'(Win) - 1;
      if (hit[i]) begin
        nv++;
        if (kk > kmax) kmax = kk;
      end
    end
    for (int idx = 0; idx < Len; idx++) begin
      key_a = wv[0][idx];
      key_b = wv[1][idx];
      key_c = wv[2][idx];
      start = (idx == T0) || (xs && idx == T0 + 1);
      if (idx == T0) begin
        s_cyc     = cyc;
        e.v       = {hit[2], hit[1], hit[0]};
        e.c       = 2'(nv);
        e.end_cyc = (nv == 3) ? s_cyc + 2 + kmax : s_cyc + 1 + int'(Win);
        sb_q.push_back(e);
      end
      if (idx == T0 + 1) begin
        @(negedge clk);
        chk("busy_on_entry", int'(busy), 1);
        chk("cnt_on_entry", int'(voted_cnt), 0);
        chk("votes_on_entry", int'({vote_c, vote_b, vote_a}), 0);
      end
      step();
    end
    start = 1'b0;
    key_a = 1'b0;
    key_b = 1'b0;
    key_c = 1'b0;
    repeat (2 * Deb + 8) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset with keys held high: nothing may leak through.
    rst   = 1'b1;
    start = 1'b0;
    key_a = 1'b1;
    key_b = 1'b1;
    key_c = 1'b1;
    repeat (3) step();
    @(negedge clk);
    chk("rst_votes", int'({vote_c, vote_b, vote_a}), 0);
    chk("rst_cnt", int'(voted_cnt), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_valid", int'(votes_valid), 0);
    rst = 1'b0;
    repeat (12) step();
    @(negedge clk);
    chk("idle_votes", int'({vote_c, vote_b, vote_a}), 0);
    chk("idle_cnt", int'(voted_cnt), 0);
    chk("idle_busy", int'(busy), 0);
    key_a = 1'b0;
    key_b = 1'b0;
    key_c = 1'b0;
    repeat (16) step();

    // Directed sessions.
    run_session(1, 0, 0, -2, 0, 0, 1'b0);                          // A only, full window
    run_session(0, 3, 0, 0, 0, 0, 1'b0);                           // B bounces only
    run_session(1, 1, 1, 0, 0, 0, 1'b1);                           // simultaneous, early exit
    run_session(0, 0, 1, 0, 0, int'(Win) - 2 - int'(Deb), 1'b0);   // C in last window cycle
    run_session(0, 0, 1, 0, 0, int'(Win) - 1 - int'(Deb), 1'b0);   // C lands in DONE
    run_session(2, 2, 0, 3, 5, 0, 1'b0);                           // bounce then settle

    // Reset in the middle of a session with vote_a already latched.
    start = 1'b1;
    key_a = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    @(negedge clk);
    chk("mid_vote_a", int'(vote_a), 1);
    chk("mid_cnt", int'(voted_cnt), 1);
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("abort_votes", int'({vote_c, vote_b, vote_a}), 0);
    chk("abort_cnt", int'(voted_cnt), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_valid", int'(votes_valid), 0);
    rst   = 1'b0;
    key_a = 1'b0;
    repeat (20) step();

    // Randomised sessions.
    for (int n = 0; n < 30; n++) begin
      run_session(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                  int'($urandom_range(0, 3)),
                  int'($urandom_range(0, Win + 3)) - int'(Deb + 3),
                  int'($urandom_range(0, Win + 3)) - int'(Deb + 3),
                  int'($urandom_range(0, Win + 3)) - int'(Deb + 3),
                  1'($urandom_range(0, 1)));
    end

    repeat (5) step();
    chk("sessions_outstanding", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
